// File: rtl/mem_arb_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
   typedef enum logic {REQ_IF, REQ_D} req_id_t;

endpackage

// File: rtl/mem_arb_prio_sel.sv
// Winner selection between fetch and load/store, plus the starvation counter's next value.
module mem_arb_prio_sel #(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic             i_if_req,
   input  logic             i_d_req,
   input  logic [CNT_W-1:0] i_count,
   output logic             o_winner,
   output logic [CNT_W-1:0] o_count_next
);
   import mem_arb_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   req_id_t winner;

   always_comb begin
      winner       = REQ_IF;
      o_count_next = i_count;
      // Data normally wins; a fetch that has waited out STARVE_MAX data grants takes the slot.
      if (i_if_req && (i_count == CNT_MAX)) begin
         winner = REQ_IF;
      end else if (i_d_req) begin
         winner = REQ_D;
      end

      if (winner == REQ_D) begin
         if (i_if_req && (i_count != CNT_MAX)) begin
            o_count_next = i_count + 1'b1;
         end
      end else if (i_if_req) begin
         o_count_next = '0;
      end
   end

   assign o_winner = winner;

endmodule

// File: rtl/instr_data_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// one access in flight at a time (IDLE -> ACCESS -> RESP).
module instr_data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              i_Clk,
   input  logic              i_Reset,
   input  logic              i_IfReq,
   input  logic [ADDR_W-1:0] i_IfAddr,
   output logic              o_IfGnt,
   output logic              o_IfValid,
   output logic [DATA_W-1:0] o_IfRData,
   input  logic              i_DReq,
   input  logic              i_DWe,
   input  logic [ADDR_W-1:0] i_DAddr,
   input  logic [DATA_W-1:0] i_DWData,
   output logic              o_DGnt,
   output logic              o_DValid,
   output logic [DATA_W-1:0] o_DRData,
   output logic              o_MemWEnable,
   output logic [ADDR_W-1:0] o_MemAddr,
   output logic [DATA_W-1:0] o_MemWData,
   input  logic [DATA_W-1:0] i_MemRData
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   arb_state_t        state_q, state_d;
   req_id_t           id_q, id_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  count_next;
   logic              win_is_d;
   logic              in_access;
   logic              in_resp;

   mem_arb_prio_sel #(
      .STARVE_MAX (STARVE_MAX),
      .CNT_W      (CNT_W)
   ) u_prio_sel (
      .i_if_req     (i_IfReq),
      .i_d_req      (i_DReq),
      .i_count      (count_q),
      .o_winner     (win_is_d),
      .o_count_next (count_next)
   );

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      count_d = count_q;
      case (state_q)
         ARB_IDLE: begin
            if (i_IfReq || i_DReq) begin
               count_d = count_next;
               state_d = ARB_ACCESS;
               if (win_is_d) begin
                  id_d    = REQ_D;
                  we_d    = i_DWe;
                  addr_d  = i_DAddr;
                  wdata_d = i_DWData;
               end else begin
                  id_d    = REQ_IF;
                  we_d    = 1'b0;
                  addr_d  = i_IfAddr;
                  wdata_d = '0;
               end
            end
         end
         ARB_ACCESS: begin
            // Stores report zero data, so there is nothing to capture for them.
            rdata_d = ((id_q == REQ_D) && we_q) ? '0 : i_MemRData;
            state_d = ARB_RESP;
         end
         ARB_RESP: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Reset) begin
         state_q <= ARB_IDLE;
         id_q    <= REQ_IF;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         count_q <= count_d;
      end
   end

   // Every output is a gated copy of registered state, so reset alone zeroes them.
   assign in_access    = (state_q == ARB_ACCESS);
   assign in_resp      = (state_q == ARB_RESP);
   assign o_IfGnt      = in_access && (id_q == REQ_IF);
   assign o_DGnt       = in_access && (id_q == REQ_D);
   assign o_IfValid    = in_resp && (id_q == REQ_IF);
   assign o_DValid     = in_resp && (id_q == REQ_D);
   assign o_IfRData    = o_IfValid ? rdata_q : '0;
   assign o_DRData     = o_DValid ? rdata_q : '0;
   assign o_MemWEnable = in_access && (id_q == REQ_D) && we_q;
   assign o_MemAddr    = in_access ? addr_q : '0;
   assign o_MemWData   = in_access ? wdata_q : '0;

endmodule

// File: tb/tb_instr_data_mem_arbiter.sv
// Random and directed stimulus checked cycle by cycle against a transaction-level model.
module tb_instr_data_mem_arbiter;

   localparam int STARVE_MAX = 4;
   localparam int MAXC       = 2200;

   logic        i_Clk = 1'b0;
   logic        i_Reset;
   logic        i_IfReq;
   logic [31:0] i_IfAddr;
   logic        o_IfGnt;
   logic        o_IfValid;
   logic [31:0] o_IfRData;
   logic        i_DReq;
   logic        i_DWe;
   logic [31:0] i_DAddr;
   logic [31:0] i_DWData;
   logic        o_DGnt;
   logic        o_DValid;
   logic [31:0] o_DRData;
   logic        o_MemWEnable;
   logic [31:0] o_MemAddr;
   logic [31:0] o_MemWData;
   logic [31:0] i_MemRData;

   logic [31:0] mem_arr [16];
   logic [31:0] ref_mem [16];

   bit        exp_ifgnt [MAXC];
   bit        exp_dgnt  [MAXC];
   bit        exp_ifval [MAXC];
   bit        exp_dval  [MAXC];
   bit        exp_we    [MAXC];
   bit [31:0] exp_ifr   [MAXC];
   bit [31:0] exp_dr    [MAXC];
   bit [31:0] exp_addr  [MAXC];
   bit [31:0] exp_wdata [MAXC];

   int cyc       = 0;
   int next_free = 0;
   int starve    = 0;
   int n_vec     = 0;
   int n_mis     = 0;
   int n_txn     = 0;
   bit rec       = 1'b0;
   int n_order   = 0;
   logic [9:0] order = '0;

   instr_data_mem_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .i_Clk        (i_Clk),
      .i_Reset      (i_Reset),
      .i_IfReq      (i_IfReq),
      .i_IfAddr     (i_IfAddr),
      .o_IfGnt      (o_IfGnt),
      .o_IfValid    (o_IfValid),
      .o_IfRData    (o_IfRData),
      .i_DReq       (i_DReq),
      .i_DWe        (i_DWe),
      .i_DAddr      (i_DAddr),
      .i_DWData     (i_DWData),
      .o_DGnt       (o_DGnt),
      .o_DValid     (o_DValid),
      .o_DRData     (o_DRData),
      .o_MemWEnable (o_MemWEnable),
      .o_MemAddr    (o_MemAddr),
      .o_MemWData   (o_MemWData),
      .i_MemRData   (i_MemRData)
   );

   always #5 i_Clk = ~i_Clk;

   assign i_MemRData = mem_arr[o_MemAddr[5:2]];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // Transaction-level model: the port is free again three edges after a grant;
   // the result is the memory word as of the grant, one cycle after the grant.
   task automatic model_edge();
      int          e;
      bit          take_if;
      bit          is_store;
      logic [31:0] a;
      logic [31:0] v;
      e = cyc;
      if (!i_Reset) begin
         exp_ifval[e] = 1'b0;
         exp_dval[e]  = 1'b0;
         exp_ifr[e]   = '0;
         exp_dr[e]    = '0;
         next_free    = e + 1;
         starve       = 0;
      end else if ((e >= next_free) && (i_IfReq || i_DReq)) begin
         take_if  = (i_IfReq && (starve == STARVE_MAX)) || !i_DReq;
         is_store = !take_if && i_DWe;
         a        = take_if ? i_IfAddr : i_DAddr;
         if (take_if) begin
            starve = 0;
         end else if (i_IfReq) begin
            starve = (starve + 1 > STARVE_MAX) ? STARVE_MAX : starve + 1;
         end
         exp_ifgnt[e] = take_if;
         exp_dgnt[e]  = !take_if;
         exp_addr[e]  = a;
         exp_we[e]    = is_store;
         exp_wdata[e] = is_store ? i_DWData : 32'h0;
         if (is_store) begin
            ref_mem[a[5:2]] = i_DWData;
            v = 32'h0;
         end else begin
            v = ref_mem[a[5:2]];
         end
         if (take_if) begin
            exp_ifval[e+1] = 1'b1;
            exp_ifr[e+1]   = v;
         end else begin
            exp_dval[e+1] = 1'b1;
            exp_dr[e+1]   = v;
         end
         next_free = e + 3;
         $display("txn %0d cyc=%0d %s %s addr=%h data=%h", n_txn, e,
                  take_if ? "IF" : "D", is_store ? "st" : "rd", a, is_store ? i_DWData : v);
         n_txn++;
      end
   endtask

   task automatic step();
      @(posedge i_Clk);
      if (o_MemWEnable) mem_arr[o_MemAddr[5:2]] = o_MemWData;
      model_edge();
      #1;
      check_val("if_gnt",   {31'b0, o_IfGnt},      {31'b0, exp_ifgnt[cyc]});
      check_val("d_gnt",    {31'b0, o_DGnt},       {31'b0, exp_dgnt[cyc]});
      check_val("if_valid", {31'b0, o_IfValid},    {31'b0, exp_ifval[cyc]});
      check_val("d_valid",  {31'b0, o_DValid},     {31'b0, exp_dval[cyc]});
      check_val("if_rdata", o_IfRData,             exp_ifr[cyc]);
      check_val("d_rdata",  o_DRData,              exp_dr[cyc]);
      check_val("mem_we",   {31'b0, o_MemWEnable}, {31'b0, exp_we[cyc]});
      check_val("mem_addr", o_MemAddr,             exp_addr[cyc]);
      if (exp_we[cyc] || !(exp_ifgnt[cyc] || exp_dgnt[cyc]))
         check_val("mem_wdata", o_MemWData, exp_wdata[cyc]);
      if (rec && (o_IfGnt || o_DGnt) && (n_order < 10)) begin
         order = {order[8:0], o_IfGnt};
         n_order++;
      end
      if (exp_ifgnt[cyc]) i_IfReq = 1'b0;
      if (exp_dgnt[cyc])  i_DReq  = 1'b0;
      cyc++;
      @(negedge i_Clk);
   endtask

   initial begin
      logic [31:0] r;
      for (int i = 0; i < 16; i++) begin
         r = $urandom;
         mem_arr[i] = r;
         ref_mem[i] = r;
      end
      mem_arr[4] = 32'h00500093;
      ref_mem[4] = 32'h00500093;
      i_Reset  = 1'b0;
      i_IfReq  = 1'b1;
      i_IfAddr = 32'h0;
      i_DReq   = 1'b1;
      i_DWe    = 1'b0;
      i_DAddr  = 32'h4;
      i_DWData = 32'h0;
      @(negedge i_Clk);

      // reset with both requests held
      repeat (2) step();
      i_IfReq = 1'b0;
      i_DReq  = 1'b0;
      i_Reset = 1'b1;
      step();

      // single fetch
      i_IfReq  = 1'b1;
      i_IfAddr = 32'h10;
      repeat (4) step();

      // simultaneous fetch and load
      i_IfReq  = 1'b1;
      i_IfAddr = 32'h0000_0108;
      i_DReq   = 1'b1;
      i_DWe    = 1'b0;
      i_DAddr  = 32'h0000_0034;
      repeat (8) step();

      // store then read back
      i_DReq   = 1'b1;
      i_DWe    = 1'b1;
      i_DAddr  = 32'h20;
      i_DWData = 32'hDEADBEEF;
      repeat (4) step();
      i_DReq = 1'b1;
      i_DWe  = 1'b0;
      repeat (4) step();

      // starvation with both requesters saturating the port
      i_Reset = 1'b0;
      step();
      i_Reset = 1'b1;
      i_IfReq = 1'b1;
      i_DReq  = 1'b1;
      rec     = 1'b1;
      repeat (36) begin
         step();
         if (!i_IfReq) begin
            i_IfReq  = 1'b1;
            i_IfAddr = $urandom;
         end
         if (!i_DReq) begin
            i_DReq   = 1'b1;
            i_DWe    = 1'($urandom_range(0, 1));
            i_DAddr  = $urandom;
            i_DWData = $urandom;
         end
      end
      rec = 1'b0;
      check_val("starve_cnt",   n_order,          10);
      check_val("starve_order", {22'b0, order},   {22'b0, 10'b0000100001});
      i_IfReq = 1'b0;
      i_DReq  = 1'b0;
      repeat (3) step();

      // reset during a store's access cycle
      i_DReq   = 1'b1;
      i_DWe    = 1'b1;
      i_DAddr  = 32'h0000_0A3C;
      i_DWData = 32'h1234_5678;
      step();
      i_Reset = 1'b0;
      step();
      i_Reset = 1'b1;
      repeat (2) step();

      // random traffic with cancels and occasional resets
      repeat (1500) begin
         step();
         i_Reset = ($urandom_range(0, 199) != 0);
         if (!i_IfReq && ($urandom_range(0, 2) == 0)) begin
            i_IfReq  = 1'b1;
            i_IfAddr = $urandom;
         end else if (i_IfReq && ($urandom_range(0, 19) == 0)) begin
            i_IfReq = 1'b0;
         end
         if (!i_DReq && ($urandom_range(0, 2) == 0)) begin
            i_DReq   = 1'b1;
            i_DWe    = 1'($urandom_range(0, 1));
            i_DAddr  = $urandom;
            i_DWData = $urandom;
         end else if (i_DReq && ($urandom_range(0, 19) == 0)) begin
            i_DReq = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
